// File: rtl/sram_confreg_responder.sv
// Peripheral responder on the data SRAM-like port: LED, switches, timer with
// compare interrupt, and a small TX byte FIFO feeding a debug UART.
module sram_confreg_responder #(
  parameter logic [15:0] BASE       = 16'hBFAF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_en,
  input  logic [3:0]  io_wen,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [7:0]  io_switch,
  output logic [15:0] io_led,
  output logic        io_timer_int,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_COMPARE = 16'h000C;
  localparam logic [15:0] OFF_STATUS  = 16'h0010;
  localparam logic [15:0] OFF_TX      = 16'h0014;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [15:0]   off;
  logic          hit, rd_req, wr_req;
  logic [31:0]   timer, compare;
  logic          timer_int_q, overflow;
  logic [15:0]   led_q;
  logic [31:0]   rdata_q, rdata_next, status_word;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, pop, push_req, push_ok;
  logic          timer_wr, timer_match, int_clr, ovf_clr;
  logic          unused_addr_bits;

  // Word offset: the two byte-select bits never change the target register.
  assign off              = {io_addr[15:2], 2'b00};
  assign unused_addr_bits = ^io_addr[1:0];
  assign hit              = io_en && (io_addr[31:16] == BASE);
  assign rd_req           = hit && (io_wen == 4'b0000);
  assign wr_req           = hit && (io_wen != 4'b0000);

  assign fifo_full   = (count == DEPTH_C);
  assign fifo_empty  = (count == '0);
  assign pop         = !fifo_empty && io_tx_ready;
  assign push_req    = wr_req && (off == OFF_TX) && io_wen[0];
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push_ok     = push_req && (!fifo_full || pop);

  assign timer_wr    = wr_req && (off == OFF_TIMER);
  assign timer_match = (timer == compare);
  assign int_clr     = wr_req && (off == OFF_STATUS) && io_wen[0] && io_wdata[0];
  assign ovf_clr     = wr_req && (off == OFF_STATUS) && io_wen[0] && io_wdata[3];

  assign status_word = {25'b0, 3'(count), overflow, fifo_empty, fifo_full, timer_int_q};

  // Read data mux, sampling pre-update register values.
  always_comb begin
    // NOTE: default assigned first so every path drives rdata_next and no latch is inferred.
    rdata_next = 32'h0;
    if (rd_req) begin
      case (off)
        OFF_LED:     rdata_next = {16'h0, led_q};
        OFF_SWITCH:  rdata_next = {24'h0, io_switch};
        OFF_TIMER:   rdata_next = timer;
        OFF_COMPARE: rdata_next = compare;
        OFF_STATUS:  rdata_next = status_word;
        default:     rdata_next = 32'h0;
      endcase
    end
  end

  // Registered read data; holds between requests.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset)      rdata_q <= 32'h0;
    else if (io_en) rdata_q <= rdata_next;
  end

  // LED register, lower two byte lanes only.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q <= 16'h0;
    end else if (wr_req && off == OFF_LED) begin
      if (io_wen[0]) led_q[7:0]  <= io_wdata[7:0];
      if (io_wen[1]) led_q[15:8] <= io_wdata[15:8];
    end
  end

  // Free-running timer (a write freezes all lanes for that cycle) and compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer   <= 32'h0;
      compare <= 32'hFFFF_FFFF;
    end else begin
      if (timer_wr) timer <= byte_merge(timer, io_wdata, io_wen);
      else          timer <= timer + 32'd1;
      if (wr_req && off == OFF_COMPARE) compare <= byte_merge(compare, io_wdata, io_wen);
    end
  end

  // Sticky interrupt and overflow flags; a new match beats a clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_int_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (timer_match)  timer_int_q <= 1'b1;
      else if (int_clr) timer_int_q <= 1'b0;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; the pointers and count define which entries are live.
    if (!reset && push_ok) fifo_mem[wr_ptr] <= io_wdata[7:0];
  end

  assign io_rdata     = rdata_q;
  assign io_led       = led_q;
  assign io_timer_int = timer_int_q;
  assign io_tx_valid  = !fifo_empty;
  assign io_tx_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_sram_confreg_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_sram_confreg_responder;

  localparam logic [15:0] BASE  = 16'hBFAF;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_en;
  logic [3:0]  io_wen;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [7:0]  io_switch;
  logic [15:0] io_led;
  logic        io_timer_int, io_tx_valid, io_tx_ready;
  logic [7:0]  io_tx_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_rdata, m_timer, m_cmp;
  logic [15:0] m_led;
  logic        m_int, m_ovf;
  logic [7:0]  m_fifo [$];
  logic        cur_rdy;

  sram_confreg_responder #(.BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .io_en(io_en), .io_wen(io_wen),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_switch(io_switch), .io_led(io_led), .io_timer_int(io_timer_int),
    .io_tx_valid(io_tx_valid), .io_tx_data(io_tx_data), .io_tx_ready(io_tx_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = m_fifo.size();
    return {25'b0, 3'(n), m_ovf, (n == 0), (n == DEPTH), m_int};
  endfunction

  // One clock cycle: drive, advance the model, then compare after the edge.
  task automatic do_cycle(input logic rst, input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] sw, input logic rdy);
    logic        hit, wr;
    logic [15:0] off;
    logic [31:0] n_rdata, n_timer, tmp;
    logic        match;
    reset = rst; io_en = en; io_wen = wen; io_addr = addr; io_wdata = wdata;
    io_switch = sw; io_tx_ready = rdy;
    if (rst) begin
      m_rdata = 0; m_led = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
      m_int = 0; m_ovf = 0; m_fifo.delete();
    end else begin
      hit = en && (addr[31:16] == BASE);
      wr  = hit && (wen != 0);
      off = {addr[15:2], 2'b00};
      n_rdata = m_rdata;
      if (en) begin
        n_rdata = 0;
        if (hit && wen == 0) begin
          case (off)
            16'h0000: n_rdata = {16'h0, m_led};
            16'h0004: n_rdata = {24'h0, sw};
            16'h0008: n_rdata = m_timer;
            16'h000C: n_rdata = m_cmp;
            16'h0010: n_rdata = m_status();
            default:  n_rdata = 0;
          endcase
        end
      end
      match   = (m_timer == m_cmp);
      n_timer = (wr && off == 16'h0008) ? merge(m_timer, wdata, wen) : m_timer + 1;
      if (wr && off == 16'h0000) begin
        tmp = merge({16'h0, m_led}, wdata, {2'b00, wen[1:0]});
        m_led = tmp[15:0];
      end
      if (wr && off == 16'h000C) m_cmp = merge(m_cmp, wdata, wen);
      if (match) m_int = 1;
      else if (wr && off == 16'h0010 && wen[0] && wdata[0]) m_int = 0;
      if (wr && off == 16'h0010 && wen[0] && wdata[3]) m_ovf = 0;
      if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
      if (wr && off == 16'h0014 && wen[0]) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(wdata[7:0]);
        else m_ovf = 1;
      end
      m_timer = n_timer;
      m_rdata = n_rdata;
    end
    @(posedge clock); #1;
    check("rdata", io_rdata, m_rdata);
    check("led", {16'h0, io_led}, {16'h0, m_led});
    check("timer_int", {31'h0, io_timer_int}, {31'h0, m_int});
    check("tx_valid", {31'h0, io_tx_valid}, {31'h0, (m_fifo.size() != 0)});
    if (m_fifo.size() != 0) check("tx_data", {24'h0, io_tx_data}, {24'h0, m_fifo[0]});
  endtask

  task automatic wr_reg(input logic [15:0] off, input logic [31:0] d, input logic [3:0] wen);
    do_cycle(1'b0, 1'b1, wen, {BASE, off}, d, 8'h00, cur_rdy);
  endtask

  task automatic rd_reg(input logic [15:0] off);
    do_cycle(1'b0, 1'b1, 4'h0, {BASE, off}, 32'h0, 8'h00, cur_rdy);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00, cur_rdy);
  endtask

  task automatic do_reset();
    do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00, 1'b0);
    do_cycle(1'b1, 1'b1, 4'hF, {BASE, 16'h0000}, 32'hFFFF_FFFF, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic        rdy;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [31:0] t0, t1;
    logic [7:0]  exp_q [4];

    vecs[0]  = '{1'b1, 4'b0001, 32'hBFAF0000, 32'h0000A5A5, 8'h00, 1'b0, 32'h0,         16'h00A5, 1'b0};
    vecs[1]  = '{1'b1, 4'b0011, 32'hBFAF0000, 32'h0000A5A5, 8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[2]  = '{1'b1, 4'b0000, 32'hBFAF0000, 32'h0,        8'h00, 1'b0, 32'h0000A5A5,  16'hA5A5, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 32'hBFAF0004, 32'h0,        8'h3C, 1'b0, 32'h0000003C,  16'hA5A5, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 32'hBFAF0004, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[5]  = '{1'b1, 4'b0000, 32'hBFAF000C, 32'h0,        8'h00, 1'b0, 32'hFFFFFFFF,  16'hA5A5, 1'b0};
    vecs[6]  = '{1'b1, 4'b0100, 32'hBFAF000C, 32'h00120000, 8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[7]  = '{1'b1, 4'b0000, 32'hBFAF000C, 32'h0,        8'h00, 1'b0, 32'hFF12FFFF,  16'hA5A5, 1'b0};
    vecs[8]  = '{1'b1, 4'b0000, 32'h9FAF0004, 32'h0,        8'hFF, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 32'hBFAF0000, 32'h0,        8'h00, 1'b0, 32'h0000A5A5,  16'hA5A5, 1'b0};
    vecs[10] = '{1'b1, 4'b0000, 32'hBFAF0020, 32'h0,        8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 32'h9FAF0000, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[12] = '{1'b1, 4'b1111, 32'hBFAF0020, 32'hFFFFFFFF, 8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b0};
    vecs[13] = '{1'b1, 4'b0000, 32'hBFAF0002, 32'h0,        8'h00, 1'b0, 32'h0000A5A5,  16'hA5A5, 1'b0};
    vecs[14] = '{1'b1, 4'b0000, 32'hBFAF0010, 32'h0,        8'h00, 1'b0, 32'h00000004,  16'hA5A5, 1'b0};
    vecs[15] = '{1'b1, 4'b0001, 32'hBFAF0014, 32'h00000041, 8'h00, 1'b0, 32'h0,         16'hA5A5, 1'b1};
    vecs[16] = '{1'b1, 4'b0000, 32'hBFAF0010, 32'h0,        8'h00, 1'b0, 32'h00000010,  16'hA5A5, 1'b1};
    vecs[17] = '{1'b0, 4'b0000, 32'hBFAF0000, 32'h0,        8'h00, 1'b0, 32'h00000010,  16'hA5A5, 1'b1};

    cur_rdy = 1'b0;
    do_reset();
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_led", {16'h0, io_led}, 32'h0);
    check("reset_int", {31'h0, io_timer_int}, 32'h0);
    check("reset_valid", {31'h0, io_tx_valid}, 32'h0);
    check("reset_txdata", {24'h0, io_tx_data}, 32'h0);

    // Timer back-to-back reads, then interrupt timing and W1C races.
    rd_reg(16'h0008); t0 = io_rdata;
    rd_reg(16'h0008); t1 = io_rdata;
    check("timer_first", t0, 32'h0);
    check("timer_delta", t1 - t0, 32'h1);
    wr_reg(16'h000C, 32'd20, 4'hF);
    wr_reg(16'h0008, 32'd10, 4'hF);
    for (int j = 1; j <= 10; j++) idle();
    check("int_before_match", {31'h0, io_timer_int}, 32'h0);
    idle();
    check("int_after_match", {31'h0, io_timer_int}, 32'h1);
    wr_reg(16'h0010, 32'h1, 4'h1);
    check("int_w1c", {31'h0, io_timer_int}, 32'h0);
    wr_reg(16'h0008, 32'd15, 4'hF);
    for (int j = 1; j <= 5; j++) idle();
    wr_reg(16'h0010, 32'h1, 4'h1);
    check("int_set_wins", {31'h0, io_timer_int}, 32'h1);
    wr_reg(16'h0010, 32'h1, 4'h1);
    check("int_w1c_again", {31'h0, io_timer_int}, 32'h0);

    // Directed register map table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      do_cycle(1'b0, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
               vecs[i].sw, vecs[i].rdy);
      check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), {16'h0, io_led}, {16'h0, vecs[i].exp_led});
      check($sformatf("vec%0d_valid", i), {31'h0, io_tx_valid}, {31'h0, vecs[i].exp_valid});
    end

    // Overflow on a full FIFO, then in-order drain.
    do_reset();
    cur_rdy = 1'b0;
    for (int i = 0; i < 5; i++) wr_reg(16'h0014, 32'h41 + i, 4'h1);
    rd_reg(16'h0010);
    check("ovf_status", io_rdata, 32'h0000004A);
    cur_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'h0, io_tx_valid}, 32'h1);
      check("drain_data", {24'h0, io_tx_data}, 32'h41 + i);
      idle();
    end
    check("drain_done", {31'h0, io_tx_valid}, 32'h0);
    rd_reg(16'h0010);
    check("drain_status", io_rdata, 32'h0000000C);

    // Push into a full FIFO in the same cycle as a pop.
    do_reset();
    cur_rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr_reg(16'h0014, 32'h61 + i, 4'h1);
    cur_rdy = 1'b1;
    wr_reg(16'h0014, 32'h50, 4'h1);
    cur_rdy = 1'b0;
    rd_reg(16'h0010);
    check("popush_status", io_rdata, 32'h00000042);
    exp_q = '{8'h62, 8'h63, 8'h64, 8'h50};
    cur_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("popush_data", {24'h0, io_tx_data}, {24'h0, exp_q[i]});
      idle();
    end
    check("popush_empty", {31'h0, io_tx_valid}, 32'h0);

    // Reset in the middle of a drain discards the FIFO.
    cur_rdy = 1'b0;
    for (int i = 0; i < 3; i++) wr_reg(16'h0014, 32'h70 + i, 4'h1);
    cur_rdy = 1'b1;
    idle();
    do_reset();
    check("rst_drain_valid", {31'h0, io_tx_valid}, 32'h0);
    check("rst_drain_data", {24'h0, io_tx_data}, 32'h0);
    rd_reg(16'h0010);
    check("rst_drain_status", io_rdata, 32'h00000004);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_en, r_rdy;
      logic [3:0]  r_wen;
      logic [31:0] r_addr, r_wdata;
      logic [15:0] r_off;
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      case ($urandom_range(0, 8))
        0: r_off = 16'h0000;
        1: r_off = 16'h0004;
        2: r_off = 16'h0008;
        3: r_off = 16'h000C;
        4: r_off = 16'h0010;
        5, 6: r_off = 16'h0014;
        7: r_off = 16'h0020;
        default: r_off = 16'($urandom);
      endcase
      r_off[1:0] = 2'($urandom);
      r_addr  = {(($urandom_range(0, 6) == 0) ? 16'($urandom) : BASE), r_off};
      r_wdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom);
      r_rdy   = 1'($urandom);
      do_cycle(r_rst, r_en, r_wen, r_addr, r_wdata, 8'($urandom), r_rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
